// File: rtl/kbd_fifo.sv
// Scancode FIFO between ps2keyboard and memctrl: edge-detected push/pop, show-ahead head byte, sticky overflow.
// Optional key-release filter enabled by defining KBD_FIFO_BREAK_FILTER_EN.
module kbd_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            ps2_data,
  input  logic                  ps2_hit,
  input  logic                  rd,
  input  logic                  ovf_clr,
  output logic [7:0]            q,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovf
);

  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          hit_q, rd_q;

  logic push_ev, pop_ev, store, do_push, do_pop, overflow;

  assign push_ev = ps2_hit & ~hit_q;
  assign pop_ev  = rd & ~rd_q;

`ifdef KBD_FIFO_BREAK_FILTER_EN
  typedef enum logic {PASS, BREAK} filt_e;
  filt_e filt_q, filt_d;

  always_comb begin
    filt_d = filt_q;
    store  = 1'b0;
    if (push_ev) begin
      unique case (filt_q)
        PASS: begin
          if (ps2_data == 8'hF0) filt_d = BREAK;
          else                   store  = 1'b1;
        end
        BREAK: filt_d = PASS;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) filt_q <= PASS;
    else       filt_q <= filt_d;
  end
`else
  assign store = push_ev;
`endif

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign ovf   = ovf_q;
  assign q     = empty ? 8'h00 : mem_q[rd_ptr_q];

  // A pop while full frees the slot, so the simultaneous push is accepted.
  assign do_pop   = pop_ev & ~empty;
  assign do_push  = store & (~full | do_pop);
  assign overflow = store & full & ~do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
    if (ovf_clr)  ovf_d = 1'b0;
    if (overflow) ovf_d = 1'b1;
  end

  // NOTE: non-blocking assignments for all state; hit_q resets to 1 so a held ps2_hit is not a push after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      hit_q    <= 1'b1;
      rd_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      hit_q    <= ps2_hit;
      rd_q     <= rd;
    end
  end

  // NOTE: storage has no reset; empty/count gate q, so stale bytes are never visible.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= ps2_data;
  end

endmodule

// File: tb/tb_kbd_fifo.sv
// Directed self-checking bench for kbd_fifo (DEPTH_LOG2=4); honours KBD_FIFO_BREAK_FILTER_EN.
module tb_kbd_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] ps2_data;
  logic       ps2_hit;
  logic       rd;
  logic       ovf_clr;
  logic [7:0] q;
  logic       empty, full, ovf;
  logic [4:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  kbd_fifo #(.DEPTH_LOG2(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .ps2_data (ps2_data),
    .ps2_hit  (ps2_hit),
    .rd       (rd),
    .ovf_clr  (ovf_clr),
    .q        (q),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .ovf      (ovf)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; one rising edge sees the pulse.
  task automatic push(input logic [7:0] d);
    ps2_data = d;
    ps2_hit  = 1'b1;
    @(negedge clock);
    ps2_hit  = 1'b0;
    @(negedge clock);
  endtask

  task automatic pop();
    rd = 1'b1;
    @(negedge clock);
    rd = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_state(input string tag, input logic [7:0] eq, input logic [4:0] ecnt,
                             input logic ee, input logic ef, input logic eo);
    check({tag, ".q"},     32'(q),     32'(eq));
    check({tag, ".count"}, 32'(count), 32'(ecnt));
    check({tag, ".empty"}, 32'(empty), 32'(ee));
    check({tag, ".full"},  32'(full),  32'(ef));
    check({tag, ".ovf"},   32'(ovf),   32'(eo));
  endtask

  logic [7:0] filt_in [5] = '{8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h75};
`ifdef KBD_FIFO_BREAK_FILTER_EN
  localparam int FILT_N = 3;
  logic [7:0] filt_exp [5] = '{8'h1C, 8'hE0, 8'h75, 8'h00, 8'h00};
`else
  localparam int FILT_N = 5;
  logic [7:0] filt_exp [5] = '{8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h75};
`endif

  initial begin
    reset = 1'b1; ps2_data = 8'h00; ps2_hit = 1'b0; rd = 1'b0; ovf_clr = 1'b0;
    #1;
    check_state("reset", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Basic push/pop and show-ahead
    push(8'h1C); push(8'h32); push(8'h21);
    check_state("push3", 8'h1C, 5'd3, 1'b0, 1'b0, 1'b0);
    pop();
    check_state("pop1", 8'h32, 5'd2, 1'b0, 1'b0, 1'b0);
    pop(); pop();
    check_state("drain", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0);
    pop();
    check_state("pop_empty", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0);

    // Held-high ps2_hit and held-high rd each act once
    ps2_data = 8'h5A; ps2_hit = 1'b1;
    repeat (10) @(negedge clock);
    ps2_hit = 1'b0;
    @(negedge clock);
    check_state("hold_hit", 8'h5A, 5'd1, 1'b0, 1'b0, 1'b0);
    push(8'h6B);
    rd = 1'b1;
    repeat (5) @(negedge clock);
    rd = 1'b0;
    @(negedge clock);
    check_state("hold_rd", 8'h6B, 5'd1, 1'b0, 1'b0, 1'b0);
    pop();

    // Push and pop together while empty stores the byte
    ps2_data = 8'h3C; ps2_hit = 1'b1; rd = 1'b1;
    @(negedge clock);
    ps2_hit = 1'b0; rd = 1'b0;
    @(negedge clock);
    check_state("both_empty", 8'h3C, 5'd1, 1'b0, 1'b0, 1'b0);
    pop();

    // Fill and overflow
    for (int i = 0; i < 17; i++) push(8'(i));
    check_state("overflow", 8'h00, 5'd16, 1'b0, 1'b1, 1'b1);
    ovf_clr = 1'b1;
    @(negedge clock);
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf), 32'd0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("order%0d", i), 32'(q), 32'(i));
      pop();
    end
    check_state("drained16", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0);

    // Push and pop together while full
    for (int i = 0; i < 16; i++) push(8'(i));
    ps2_data = 8'hAA; ps2_hit = 1'b1; rd = 1'b1;
    @(negedge clock);
    ps2_hit = 1'b0; rd = 1'b0;
    @(negedge clock);
    check_state("both_full", 8'h01, 5'd16, 1'b0, 1'b1, 1'b0);

    // Overflow and ovf_clr in the same clock: set wins
    ps2_data = 8'hBB; ps2_hit = 1'b1; ovf_clr = 1'b1;
    @(negedge clock);
    ps2_hit = 1'b0; ovf_clr = 1'b0;
    @(negedge clock);
    check_state("set_wins", 8'h01, 5'd16, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("full_order%0d", i), 32'(q), 32'(i));
      pop();
    end
    check("last_is_new", 32'(q), 32'hAA);
    pop();
    check("empty_after", 32'(empty), 32'd1);

    // Break-code filter (or pass-through when not built in)
    for (int i = 0; i < 5; i++) push(filt_in[i]);
    check("filt_count", 32'(count), 32'(FILT_N));
    for (int i = 0; i < FILT_N; i++) begin
      check($sformatf("filt%0d", i), 32'(q), 32'(filt_exp[i]));
      pop();
    end
    check("filt_empty", 32'(empty), 32'd1);

    // Asynchronous reset mid-sequence with ovf set and ps2_hit held high
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
    ps2_data = 8'h77; ps2_hit = 1'b1; ovf_clr = 1'b1;
    @(negedge clock);
    ovf_clr = 1'b0;
    ps2_data = 8'h99; ps2_hit = 1'b0;
    @(negedge clock);
    // ovf is still 0 here; force it set via a full FIFO is costly, so check count only
    check("pre_reset_count", 32'(count), 32'd6);
    for (int i = 0; i < 11; i++) push(8'h50);
    push(8'h51);
    check("pre_reset_ovf", 32'(ovf), 32'd1);
    ps2_hit = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_state("async_reset", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    ps2_hit = 1'b0;
    @(negedge clock);
    check_state("no_push_after_reset", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
